// File: rtl/time_set_ctrl.sv
// Digital-clock timekeeper: runs hh:mm:ss on a 1 Hz tick and edits fields via set_shift/set_time.
// Optional field blinking in set mode when TIME_SET_BLINK_EN is defined.
module time_set_ctrl #(
  parameter int HOUR_MAX  = 23,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       set_shift,
  input  logic       set_time,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] field_sel,
  output logic       setting,
  output logic [2:0] blink_mask
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t state, nxt_state;

  wire hour_max = (hour == 5'(HOUR_MAX));
  wire min_max  = (minute == 6'd59);
  wire sec_max  = (second == 6'd59);

  always_comb begin
    nxt_state = state;
    if (set_shift) nxt_state = state_t'(state + 2'd1);
  end

  assign field_sel = state;

  // set_shift has priority over both set_time and tick_1hz.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      setting <= 1'b0;
      hour    <= '0;
      minute  <= '0;
      second  <= '0;
    end else if (set_shift) begin
      state   <= nxt_state;
      setting <= (nxt_state != RUN);
    end else begin
      case (state)
        RUN: if (tick_1hz) begin
          if (sec_max) begin
            second <= '0;
            if (min_max) begin
              minute <= '0;
              hour   <= hour_max ? 5'd0 : hour + 5'd1;
            end else begin
              minute <= minute + 6'd1;
            end
          end else begin
            second <= second + 6'd1;
          end
        end
        SET_HOUR: if (set_time) hour   <= hour_max ? 5'd0 : hour + 5'd1;
        SET_MIN:  if (set_time) minute <= min_max ? 6'd0 : minute + 6'd1;
        SET_SEC:  if (set_time) second <= sec_max ? 6'd0 : second + 6'd1;
        default: ;
      endcase
    end
  end

`ifdef TIME_SET_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] blink_cnt, nxt_cnt;
  logic          phase, nxt_phase;
  logic [2:0]    nxt_mask;

  // Any key press restarts the visible half so the edited field shows at once.
  always_comb begin
    nxt_cnt   = blink_cnt + CW'(1);
    nxt_phase = phase;
    if (set_shift || set_time || state == RUN) begin
      nxt_cnt   = '0;
      nxt_phase = 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      nxt_cnt   = '0;
      nxt_phase = ~phase;
    end
    case (nxt_state)
      SET_HOUR: nxt_mask = {nxt_phase, 2'b00};
      SET_MIN:  nxt_mask = {1'b0, nxt_phase, 1'b0};
      SET_SEC:  nxt_mask = {2'b00, nxt_phase};
      default:  nxt_mask = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt  <= '0;
      phase      <= 1'b0;
      blink_mask <= 3'b000;
    end else begin
      blink_cnt  <= nxt_cnt;
      phase      <= nxt_phase;
      blink_mask <= nxt_mask;
    end
  end
`else
  logic unused_blink_div;
  assign unused_blink_div = (BLINK_DIV != 0);
  assign blink_mask       = 3'b000;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed-vector bench for time_set_ctrl: run/carry, set-mode editing, priorities, async reset, blink.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, set_shift, set_time;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [1:0] field_sel;
  logic       setting;
  logic [2:0] blink_mask;

  int vecs = 0;
  int errs = 0;

  time_set_ctrl #(.HOUR_MAX(23), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .set_shift(set_shift),
    .set_time(set_time), .hour(hour), .minute(minute), .second(second),
    .field_sel(field_sel), .setting(setting), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Hold the given strobes high for n consecutive clk edges, then release.
  task automatic drive(input logic sh, input logic st, input logic tk, input int n);
    @(negedge clk);
    set_shift = sh; set_time = st; tick_1hz = tk;
    repeat (n) @(negedge clk);
    set_shift = 1'b0; set_time = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"},   int'(hour),   h);
    chk({tag, ".minute"}, int'(minute), m);
    chk({tag, ".second"}, int'(second), s);
  endtask

  task automatic chk_mode(input string tag, input int fs);
    chk({tag, ".field_sel"}, int'(field_sel), fs);
    chk({tag, ".setting"},   int'(setting),   (fs != 0) ? 1 : 0);
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; set_shift = 1'b0; set_time = 1'b0;
    repeat (2) @(negedge clk);
    chk_time("rst", 0, 0, 0);
    chk_mode("rst", 0);
    chk("rst.blink", int'(blink_mask), 0);
    rst_n = 1'b1;

    // Plain running and second->minute carry
    drive(0, 0, 1, 59);
    chk_time("run59", 0, 0, 59);
    drive(0, 0, 1, 1);
    chk_time("run60", 0, 1, 0);

    // Hour edit wraps modulo 24, ticks ignored while setting
    drive(1, 0, 0, 1);
    chk_mode("sethr", 1);
    drive(0, 1, 0, 25);
    chk_time("hr25", 1, 1, 0);
    drive(0, 0, 1, 10);
    chk_time("frozen", 1, 1, 0);

    // Second edit wraps without carry, then back to RUN
    drive(1, 0, 0, 2);
    chk_mode("setsec", 3);
    drive(0, 1, 0, 58);
    chk_time("sec58", 1, 1, 58);
    drive(0, 1, 0, 3);
    chk_time("secwrap", 1, 1, 1);
    drive(1, 0, 0, 1);
    chk_mode("backrun", 0);
    drive(0, 0, 1, 1);
    chk_time("resume", 1, 1, 2);

    // Priorities: shift beats set_time; shift beats tick
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 4);
    chk_time("hr5", 5, 1, 2);
    drive(1, 1, 0, 1);
    chk_mode("shift_st", 2);
    chk_time("shift_st", 5, 1, 2);
    drive(1, 0, 0, 2);
    chk_mode("run2", 0);
    drive(1, 0, 1, 1);
    chk_mode("shift_tk", 1);
    chk_time("shift_tk", 5, 1, 2);

    // 23:59:59 + tick -> 00:00:00
    drive(0, 1, 0, 18);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 58);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 57);
    drive(1, 0, 0, 1);
    chk_time("max", 23, 59, 59);
    chk_mode("max", 0);
    drive(0, 0, 1, 1);
    chk_time("dayroll", 0, 0, 0);

    // 05:59:59 + tick -> 06:00:00 (hour carry below max)
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 5);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 59);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 59);
    drive(1, 0, 0, 1);
    drive(0, 0, 1, 1);
    chk_time("hrcarry", 6, 0, 0);

    // Set 12:34:56 and park in SET_MIN, then reset asynchronously mid-cycle
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 6);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 34);
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 56);
    drive(1, 0, 0, 3);
    chk_time("pre_rst", 12, 34, 56);
    chk_mode("pre_rst", 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk_mode("arst", 0);
    chk("arst.blink", int'(blink_mask), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Blink pattern in SET_MIN
    drive(1, 0, 0, 2);
    chk_mode("blk", 2);
    chk("blk.e0", int'(blink_mask), 0);
`ifdef TIME_SET_BLINK_EN
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("blk.e%0d", i), int'(blink_mask), (i >= 4) ? 3'b010 : 3'b000);
    end
    drive(0, 1, 0, 1);
    chk("blk.press", int'(blink_mask), 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("blk.r%0d", i), int'(blink_mask), (i == 4) ? 3'b010 : 3'b000);
    end
`else
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("blk.e%0d", i), int'(blink_mask), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
